bnn_xnor_accum: RTL
===================

Name: bnn_xnor_accum

Overview:
Parametrised successor to the fixed 9-bit BNN kernel. Per valid beat it computes a masked XNOR-popcount (±1 dot product) of VEC_W activation/weight bits. It accumulates these beats over a variable-length channel group delimited by in_last, then emits a saturated signed partial sum plus a binarised activation against a threshold. It sits between the activation/weight feeders and the next layer's activation buffer.

Parameters:
VEC_W, 9, bits per beat (3x3 window default)
ACC_W, 8, signed accumulator/output width; must hold at least ±VEC_W

Ports:
clk_in  input  1  clock, all state on rising edge
reset_in  input  1  synchronous, active-high reset
in_valid  input  1  beat qualifier; other inputs ignored when 0
in_last  input  1  final beat of current channel group (valid only with in_valid)
activation_in  input  VEC_W  binary activations (1 = +1, 0 = -1)
weight_in  input  VEC_W  binary weights (1 = +1, 0 = -1)
skip_in  input  VEC_W  per-bit mask; 1 = bit excluded (contributes 0)
threshold_in  input  ACC_W  signed threshold, sampled with the in_last beat
psum_out  output  ACC_W  signed group sum, held between results
bit_out  output  1  1 when psum_out >= threshold (signed compare)
sat_out  output  1  1 when the group saturated at any point
out_valid  output  1  one-cycle pulse marking a new result

Behaviour:
- Reset (reset_in=1 at an edge): psum_out=0, bit_out=0, sat_out=0, out_valid=0, accumulator=0, both pipeline stages invalidated; beats presented in that cycle are discarded.
- Beat arithmetic: active = VEC_W - popcount(skip_in); match = popcount(~(activation_in ^ weight_in) & ~skip_in); contrib = 2*match - active, signed, range [-VEC_W, +VEC_W].
- Stage 1 (edge after beat): register contrib, last flag, threshold, and valid.
- Stage 2: if stage-1 valid, sum = acc + contrib, saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky group-sat flag is set if a clamp occurs.
  - Not last: acc <= sum.
  - Last: psum_out <= sum; bit_out <= (sum >= threshold); sat_out <= group-sat OR this clamp; out_valid <= 1; acc <= 0; group-sat <= 0.
- Latency: a last beat sampled at edge k produces out_valid=1 for exactly one cycle after edge k+2.
- Outputs hold their values until the next result; out_valid is 0 otherwise.
- in_valid=0 cycles (bubbles) leave acc unchanged; any gap length is allowed.
- Back-to-back last beats: each is its own one-beat group, giving one out_valid per cycle with no interaction between groups.
- A beat following a last beat starts the new group from acc=0, with no dead cycle.
- Fully masked beat (skip all 1): contrib=0, but the beat still counts and in_last is still honoured.
- Saturation is clamp-per-add (not wrap). Once clamped, later opposite-sign beats subtract from the clamped value.
- Reset mid-group: the partial sum is lost and no out_valid is produced for that group.
- No backpressure: the consumer must accept every out_valid pulse.

Test Plan:
1. Reset, then a single beat: act=9'h1FF, wt=9'h1FF, skip=0, last=1, thr=0 -> 2 cycles later out_valid=1, psum_out=9, bit_out=1, sat_out=0.
2. Single beat: act=9'h1FF, wt=9'h000, skip=0, last=1, thr=0 -> psum_out=-9 (8'hF7), bit_out=0. Then all-masked beat (skip=9'h1FF, last=1) -> psum_out=0, bit_out=1.
3. Mask: act=wt=9'h1FF, skip=9'h00F, last=1, thr=6 -> psum_out=5, bit_out=0.
4. Group of 3 beats with 2 idle cycles between: contribs +9, -9, +3 (last on third beat), thr=3 -> exactly one out_valid; psum_out=3, bit_out=1. Immediately follow with a 1-beat group of +1 -> next cycle psum_out=1.
5. Saturation, ACC_W=8: 15 beats of +9 then a last beat of -9 -> psum_out=118 (127-9), sat_out=1. Next group of a single +9 -> psum_out=9, sat_out=0.
6. Two beats of +9, then reset_in=1 for one cycle, then a single +9 last beat -> no out_valid for the aborted group; new result psum_out=9. All outputs read 0 in the cycle after reset.

Source files
------------

// File: rtl/bnn_xnor_accum_if.sv
// Beat/result bundle between the activation/weight feeders, the BNN
// XNOR-popcount accumulator and the next layer's activation buffer.
interface bnn_xnor_accum_if #(
    parameter int VEC_W = 9,
    parameter int ACC_W = 8
);
    logic                    in_valid;
    logic                    in_last;
    logic [VEC_W-1:0]        activation_in;
    logic [VEC_W-1:0]        weight_in;
    logic [VEC_W-1:0]        skip_in;
    logic signed [ACC_W-1:0] threshold_in;
    logic signed [ACC_W-1:0] psum_out;
    logic                    bit_out;
    logic                    sat_out;
    logic                    out_valid;

    modport master (
        output in_valid, in_last, activation_in, weight_in, skip_in, threshold_in,
        input  psum_out, bit_out, sat_out, out_valid
    );

    modport slave (
        input  in_valid, in_last, activation_in, weight_in, skip_in, threshold_in,
        output psum_out, bit_out, sat_out, out_valid
    );
endinterface

// File: rtl/bnn_xnor_accum.sv
// Masked XNOR-popcount (+/-1 dot product) accumulated over in_last-delimited
// channel groups; emits a clamped signed partial sum and its binarised bit.
module bnn_xnor_accum #(
    parameter int VEC_W = 9,
    parameter int ACC_W = 8
) (
    input  logic               clk_in,
    input  logic               reset_in,
    bnn_xnor_accum_if.slave    bus
);
    localparam int PCW    = $clog2(VEC_W + 1);
    localparam int STAGES = 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [PCW-1:0] popcnt(input logic [VEC_W-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < VEC_W; i++) n = n + PCW'(v[i]);
        return n;
    endfunction

    // Beat arithmetic, purely combinational off the inputs
    logic [PCW-1:0]          match_c, active_c;
    logic signed [PCW+1:0]   diff_c;
    logic signed [ACC_W-1:0] contrib_c;

    always_comb begin
        match_c   = popcnt(~(bus.activation_in ^ bus.weight_in) & ~bus.skip_in);
        active_c  = PCW'(VEC_W) - popcnt(bus.skip_in);
        diff_c    = $signed({1'b0, match_c, 1'b0}) - $signed({2'b00, active_c});
        contrib_c = ACC_W'(diff_c);
    end

    logic [STAGES:1]         vld_pipe;
    logic signed [ACC_W-1:0] contrib_s1, thr_s1;
    logic                    last_s1, last_s2;

    logic signed [ACC_W-1:0] acc;
    logic                    grp_sat;
    logic signed [ACC_W-1:0] res_sum;
    logic                    res_bit, res_sat;

    // One guard bit is enough: |contrib| <= VEC_W fits in ACC_W
    logic signed [ACC_W:0]   sum_w;
    logic signed [ACC_W-1:0] sum_c;
    logic                    clamp_c;

    always_comb begin
        sum_w   = {acc[ACC_W-1], acc} + {contrib_s1[ACC_W-1], contrib_s1};
        clamp_c = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        sum_c   = sum_w[ACC_W-1:0];
        if (clamp_c) sum_c = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            vld_pipe      <= '0;
            contrib_s1    <= '0;
            thr_s1        <= '0;
            last_s1       <= 1'b0;
            last_s2       <= 1'b0;
            acc           <= '0;
            grp_sat       <= 1'b0;
            res_sum       <= '0;
            res_bit       <= 1'b0;
            res_sat       <= 1'b0;
            bus.psum_out  <= '0;
            bus.bit_out   <= 1'b0;
            bus.sat_out   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};

            if (bus.in_valid) begin
                contrib_s1 <= contrib_c;
                thr_s1     <= bus.threshold_in;
                last_s1    <= bus.in_last;
            end

            // Stage 2: accumulate; a last beat closes the group and resets acc
            if (vld_pipe[1]) begin
                last_s2 <= last_s1;
                if (last_s1) begin
                    res_sum <= sum_c;
                    res_bit <= (sum_c >= thr_s1);
                    res_sat <= grp_sat | clamp_c;
                    acc     <= '0;
                    grp_sat <= 1'b0;
                end else begin
                    acc     <= sum_c;
                    grp_sat <= grp_sat | clamp_c;
                end
            end

            bus.out_valid <= vld_pipe[2] & last_s2;
            if (vld_pipe[2] && last_s2) begin
                bus.psum_out <= res_sum;
                bus.bit_out  <= res_bit;
                bus.sat_out  <= res_sat;
            end
        end
    end
endmodule
